// File: rtl/vend_pkg.sv
// Shared coin constants, coin_sel encoding and dispenser state encoding for the change dispenser.
package vend_pkg;

    localparam int COIN_1  = 1;
    localparam int COIN_5  = 5;
    localparam int COIN_10 = 10;
    localparam int COIN_50 = 50;

    typedef enum logic [1:0] {
        SEL_1  = 2'b00,
        SEL_5  = 2'b01,
        SEL_10 = 2'b10,
        SEL_50 = 2'b11
    } coin_sel_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_REQ,
        ST_REL,
        ST_DONE,
        ST_FAULT
    } disp_state_e;

endpackage

// File: rtl/change_dispenser_coin_pick.sv
// Greedy coin choice: the largest denomination that does not exceed the remaining amount.
module coin_pick
    import vend_pkg::*;
#(
    parameter int AMT_W = 8
) (
    input  logic [AMT_W-1:0] remaining,
    output coin_sel_e        coin_sel,
    output logic [AMT_W-1:0] value
);

    // remaining == 0 falls through to the 1-coin choice; the FSM never pays it in that case
    always_comb begin
        coin_sel = SEL_1;
        value    = AMT_W'(COIN_1);
        if (remaining >= AMT_W'(COIN_50)) begin
            coin_sel = SEL_50;
            value    = AMT_W'(COIN_50);
        end else if (remaining >= AMT_W'(COIN_10)) begin
            coin_sel = SEL_10;
            value    = AMT_W'(COIN_10);
        end else if (remaining >= AMT_W'(COIN_5)) begin
            coin_sel = SEL_5;
            value    = AMT_W'(COIN_5);
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays a charge as 50/10/5/1 coins over a 4-phase req/ack hopper handshake.
// Optional CHANGE_TIMEOUT_EN adds a per-phase ack timeout that parks the block in FAULT.
//
// state  | meaning
// IDLE   | waiting for start
// SELECT | pick next coin, or finish when nothing remains
// REQ    | coin_req high, waiting for a fresh ack
// REL    | coin_req low, waiting for ack to fall
// DONE   | one-cycle completion pulse
// FAULT  | hopper timed out; left only by reset
module change_dispenser
    import vend_pkg::*;
#(
    parameter int AMT_W = 8
`ifdef CHANGE_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AMT_W-1:0] charge,
    input  logic             coin_ack,
    output logic             coin_req,
    output logic [1:0]       coin_sel,
    output logic             busy,
    output logic             done,
    output logic [AMT_W-1:0] remaining,
    output logic             fault
);

    disp_state_e      state_q, state_d;
    logic             coin_req_q, coin_req_d;
    coin_sel_e        coin_sel_q, coin_sel_d;
    logic [AMT_W-1:0] remaining_q, remaining_d;
    logic             ack_low_q, ack_low_d;

    coin_sel_e        pick_sel;
    logic [AMT_W-1:0] pick_value;

`ifdef CHANGE_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             fault_q, fault_d;
`endif

    // remaining only changes when a coin is accepted, so the pick stays valid throughout REQ
    coin_pick #(.AMT_W(AMT_W)) u_coin_pick (
        .remaining (remaining_q),
        .coin_sel  (pick_sel),
        .value     (pick_value)
    );

    always_comb begin
        state_d     = state_q;
        coin_req_d  = coin_req_q;
        coin_sel_d  = coin_sel_q;
        remaining_d = remaining_q;
        ack_low_d   = ack_low_q;
`ifdef CHANGE_TIMEOUT_EN
        tmr_d       = tmr_q;
        fault_d     = fault_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    remaining_d = charge;
                    state_d     = ST_SELECT;
                end
            end
            ST_SELECT: begin
                // an ack still high from an earlier handshake must fall before it can pay a coin
                ack_low_d = !coin_ack;
                if (remaining_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    coin_sel_d = pick_sel;
                    coin_req_d = 1'b1;
                    state_d    = ST_REQ;
`ifdef CHANGE_TIMEOUT_EN
                    tmr_d      = TMR_LOAD;
`endif
                end
            end
            ST_REQ: begin
                if (coin_ack && ack_low_q) begin
                    coin_req_d  = 1'b0;
                    remaining_d = remaining_q - pick_value;
                    state_d     = ST_REL;
`ifdef CHANGE_TIMEOUT_EN
                    tmr_d       = TMR_LOAD;
`endif
                end else begin
                    if (!coin_ack) begin
                        ack_low_d = 1'b1;
                    end
`ifdef CHANGE_TIMEOUT_EN
                    if (tmr_q == '0) begin
                        coin_req_d = 1'b0;
                        fault_d    = 1'b1;
                        state_d    = ST_FAULT;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
`endif
                end
            end
            ST_REL: begin
                if (!coin_ack) begin
                    state_d = ST_SELECT;
                end
`ifdef CHANGE_TIMEOUT_EN
                else if (tmr_q == '0) begin
                    fault_d = 1'b1;
                    state_d = ST_FAULT;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            coin_req_q  <= 1'b0;
            coin_sel_q  <= SEL_1;
            remaining_q <= '0;
            ack_low_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            coin_req_q  <= coin_req_d;
            coin_sel_q  <= coin_sel_d;
            remaining_q <= remaining_d;
            ack_low_q   <= ack_low_d;
        end
    end

`ifdef CHANGE_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            tmr_q   <= tmr_d;
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    assign coin_req  = coin_req_q;
    assign coin_sel  = coin_sel_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign remaining = remaining_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: payout vector table plus reset, zero-charge, stuck-ack and timeout sequences.
module tb_change_dispenser;

    typedef struct packed {
        logic [7:0]       charge;
        logic [3:0]       n;
        logic             poke;
        logic [0:9][1:0]  sel;
        logic [0:9][7:0]  rem;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] charge = 8'd0;
    logic       coin_ack = 1'b0;
    logic       coin_req;
    logic [1:0] coin_sel;
    logic       busy;
    logic       done;
    logic [7:0] remaining;
    logic       fault;

    int total = 0;
    int bad = 0;
    vec_t vecs[7];

    always #5 clk = ~clk;

`ifdef CHANGE_TIMEOUT_EN
    change_dispenser #(.AMT_W(8), .TIMEOUT_CYCLES(16)) dut (
`else
    change_dispenser #(.AMT_W(8)) dut (
`endif
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .charge    (charge),
        .coin_ack  (coin_ack),
        .coin_req  (coin_req),
        .coin_sel  (coin_sel),
        .busy      (busy),
        .done      (done),
        .remaining (remaining),
        .fault     (fault)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic wait_req(input logic lvl);
        int n = 0;
        while (coin_req !== lvl && n < 50) begin
            step();
            n++;
        end
        if (coin_req !== lvl) check("wait_coin_req", int'(coin_req), int'(lvl));
    endtask

    task automatic give_coin(input int dly, input logic [1:0] exp_sel, input logic [7:0] exp_rem, input int idx);
        wait_req(1'b1);
        check($sformatf("coin_sel[%0d]", idx), int'(coin_sel), int'(exp_sel));
        repeat (dly) step();
        check($sformatf("sel_stable[%0d]", idx), int'(coin_sel), int'(exp_sel));
        check($sformatf("req_hold[%0d]", idx), int'(coin_req), 1);
        coin_ack = 1'b1;
        wait_req(1'b0);
        check($sformatf("remaining[%0d]", idx), int'(remaining), int'(exp_rem));
        coin_ack = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check("done_pulse", int'(done), 1);
        check("done_busy", int'(busy), 1);
        step();
        check("done_width", int'(done), 0);
        check("idle_busy", int'(busy), 0);
        check("final_rem", int'(remaining), 0);
        check("req_idle", int'(coin_req), 0);
    endtask

    task automatic run_vec(input vec_t v, input int dly);
        charge = v.charge;
        start  = 1'b1;
        step();
        start  = 1'b0;
        charge = 8'hAA;
        check("busy_start", int'(busy), 1);
        for (int c = 0; c < int'(v.n); c++) begin
            give_coin(dly, v.sel[c], v.rem[c], c);
            if (v.poke && c == 0) begin
                // second start mid-payout must be dropped
                charge = 8'd9;
                start  = 1'b1;
                step();
                start  = 1'b0;
            end
        end
        wait_done();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{charge: 8'd87, n: 4'd7, poke: 1'b0,
                    sel: {2'd3, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0},
                    rem: {8'd37, 8'd27, 8'd17, 8'd7, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0}};
        vecs[1] = '{charge: 8'd255, n: 4'd6, poke: 1'b1,
                    sel: {2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0},
                    rem: {8'd205, 8'd155, 8'd105, 8'd55, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}};
        vecs[2] = '{charge: 8'd6, n: 4'd2, poke: 1'b0,
                    sel: {2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0},
                    rem: {8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}};
        vecs[3] = '{charge: 8'd49, n: 4'd9, poke: 1'b0,
                    sel: {2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0},
                    rem: {8'd39, 8'd29, 8'd19, 8'd9, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd0}};
        vecs[4] = '{charge: 8'd1, n: 4'd1, poke: 1'b0,
                    sel: {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0},
                    rem: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}};
        vecs[5] = '{charge: 8'd50, n: 4'd1, poke: 1'b0,
                    sel: {2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0},
                    rem: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}};
        vecs[6] = '{charge: 8'd65, n: 4'd3, poke: 1'b0,
                    sel: {2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0},
                    rem: {8'd15, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}};

        // reset state
        repeat (2) step();
        check("rst_coin_req", int'(coin_req), 0);
        check("rst_coin_sel", int'(coin_sel), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_remaining", int'(remaining), 0);
        check("rst_fault", int'(fault), 0);
        rst_n = 1'b1;
        step();

        // table payouts, hopper ack delay varied per vector
        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], 1 + (i % 3));
        end

        // zero charge: busy for SELECT and DONE, done seen by edge N+2, no coin
        charge = 8'd0;
        start  = 1'b1;
        step();
        start  = 1'b0;
        check("z_busy_n", int'(busy), 1);
        check("z_done_n", int'(done), 0);
        check("z_req_n", int'(coin_req), 0);
        step();
        check("z_busy_n1", int'(busy), 1);
        check("z_done_n1", int'(done), 1);
        check("z_req_n1", int'(coin_req), 0);
        step();
        check("z_busy_n2", int'(busy), 0);
        check("z_done_n2", int'(done), 0);

        // async reset in REQ with 37 left
        charge = 8'd87;
        start  = 1'b1;
        step();
        start  = 1'b0;
        give_coin(2, 2'd3, 8'd37, 0);
        wait_req(1'b1);
        check("r_rem_before", int'(remaining), 37);
        #2;
        rst_n = 1'b0;
        #1;
        check("r_req_async", int'(coin_req), 0);
        check("r_busy_async", int'(busy), 0);
        check("r_rem_async", int'(remaining), 0);
        step();
        rst_n = 1'b1;
        step();
        run_vec(vecs[2], 2);

        // ack stuck high from before the payout: no coin until it falls and rises again
        coin_ack = 1'b1;
        step();
        charge = 8'd6;
        start  = 1'b1;
        step();
        start  = 1'b0;
        wait_req(1'b1);
        repeat (5) step();
        check("s_rem_held", int'(remaining), 6);
        check("s_req_held", int'(coin_req), 1);
        coin_ack = 1'b0;
        step();
        check("s_rem_low", int'(remaining), 6);
        coin_ack = 1'b1;
        wait_req(1'b0);
        check("s_rem_once", int'(remaining), 1);
        coin_ack = 1'b0;
        give_coin(2, 2'd0, 8'd0, 1);
        wait_done();
        check("no_fault", int'(fault), 0);

`ifdef CHANGE_TIMEOUT_EN
        // hopper never answers: fault after 16 cycles in REQ, parked until reset
        begin
            int k = 0;
            charge = 8'd6;
            start  = 1'b1;
            step();
            start  = 1'b0;
            wait_req(1'b1);
            while (fault !== 1'b1 && k < 40) begin
                step();
                k++;
            end
            check("t_cycles", k, 16);
            check("t_req", int'(coin_req), 0);
            check("t_busy", int'(busy), 1);
            check("t_rem", int'(remaining), 6);
            k = 0;
            repeat (20) begin
                step();
                if (done === 1'b1) k++;
            end
            check("t_no_done", k, 0);
            check("t_fault_hold", int'(fault), 1);
            rst_n = 1'b0;
            step();
            rst_n = 1'b1;
            step();
            check("t_fault_clr", int'(fault), 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
